// File: rtl/mem_responder.sv
// Single-outstanding memory/IO responder: routes CPU requests to block RAM or to a small IO register file.
// Latency: 1 cycle for writes and IO reads, RAM_LAT+1 for RAM reads; req_ready is low whenever a request is in flight.
module mem_responder #(
    parameter int             DW      = 16,
    parameter int             AW      = 16,
    parameter int             RAM_LAT = 1,
    parameter logic [AW-1:0]  IO_BASE = 16'hFFF0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic [15:0]   sw_in,
    output logic [15:0]   led_out
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RAM_RD, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic [15:0]     sw_meta, sw_sync;
    logic [15:0]     timer_q;
    logic [15:0]     scratch_q;
    logic [15:0]     io_rdata;
    logic [15:0]     io_wdata;
    logic [3:0]      io_idx;
    logic            accept;
    logic            io_hit;
    logic            io_wr;

    assign accept   = req_valid && (state_q == IDLE);
    assign io_hit   = (req_addr[AW-1:4] == IO_BASE[AW-1:4]);
    assign io_idx   = req_addr[3:0];
    assign io_wdata = req_wdata[15:0];
    assign io_wr    = accept && req_we && io_hit;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign ram_addr   = (state_q == IDLE) ? req_addr : addr_q;
    assign ram_wdata  = req_wdata;
    assign ram_we     = accept && req_we && !io_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (!req_we && !io_hit) ? RAM_RD : RESP;
            RAM_RD:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_rdata = 16'h0000;
        case (io_idx)
            4'd0:    io_rdata = led_out;
            4'd1:    io_rdata = sw_sync;
            4'd2:    io_rdata = timer_q;
            4'd3:    io_rdata = scratch_q;
            default: io_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            resp_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr;
                if (!req_we && !io_hit) cnt_q <= CW'(RAM_LAT - 1);
                if (req_we)      resp_rdata <= '0;
                else if (io_hit) resp_rdata <= DW'(io_rdata);
            end else if (state_q == RAM_RD) begin
                if (cnt_q == '0) resp_rdata <= ram_rdata;
                else             cnt_q      <= cnt_q - 1'b1;
            end
        end
    end

    // The write lands together with that cycle's tick, so the following cycle reads wdata+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta   <= 16'h0000;
            sw_sync   <= 16'h0000;
            timer_q   <= 16'h0000;
            led_out   <= 16'h0000;
            scratch_q <= 16'h0000;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (io_wr && io_idx == 4'd2) timer_q <= io_wdata + 16'd1;
            else                         timer_q <= timer_q + 16'd1;
            if (io_wr && io_idx == 4'd0) led_out   <= io_wdata;
            if (io_wr && io_idx == 4'd3) scratch_q <= io_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a two-cycle-latency RAM model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, resp_valid;
    logic [15:0] resp_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic [15:0] sw_in, led_out;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat, wec, rbad, nrv;
    logic [15:0] rd, acc_a, acc_w;

    logic [15:0] mem [0:255];
    logic [15:0] d1, d2;

    always #5 clk = ~clk;

    mem_responder #(.DW(16), .AW(16), .RAM_LAT(2), .IO_BASE(16'hFFF0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .sw_in      (sw_in),
        .led_out    (led_out)
    );

    // RAM with read data valid two cycles after the address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        d1 <= mem[ram_addr[7:0]];
        d2 <= d1;
    end
    assign ram_rdata = d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request in the current (idle) cycle and wait up to 10 cycles for its response.
    task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] wd);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(negedge clk);
        acc_a = ram_addr;
        acc_w = ram_wdata;
        wec   = int'(ram_we);
        rbad  = 0;
        lat   = 0;
        rd    = 16'h0000;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            wec += int'(ram_we);
            if (req_ready) rbad++;
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; sw_in = 16'h5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  req_ready,  1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata",  resp_rdata, 0);
        chk("rst_led",    led_out,    0);
        chk("rst_ramwe",  ram_we,     0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 16'h0010, 16'hBEEF);
        chk("ramwr_lat",   lat,   1);
        chk("ramwr_we",    wec,   1);
        chk("ramwr_addr",  acc_a, 16'h0010);
        chk("ramwr_wdata", acc_w, 16'hBEEF);
        chk("ramwr_rdata", rd,    16'h0000);

        do_req(1'b0, 16'h0010, 16'h0000);
        chk("ramrd_lat",   lat,  3);
        chk("ramrd_rdata", rd,   16'hBEEF);
        chk("ramrd_busy",  rbad, 0);
        chk("ramrd_we",    wec,  0);

        do_req(1'b1, 16'hFFF0, 16'h00A5);
        chk("ledwr_lat", lat,     1);
        chk("ledwr_we",  wec,     0);
        chk("ledwr_led", led_out, 16'h00A5);
        do_req(1'b0, 16'hFFF0, 16'h0000);
        chk("ledrd_lat", lat, 1);
        chk("ledrd_val", rd,  16'h00A5);

        do_req(1'b1, 16'hFFF1, 16'h1234);
        chk("swwr_lat", lat,     1);
        chk("swwr_led", led_out, 16'h00A5);
        do_req(1'b0, 16'hFFF1, 16'h0000);
        chk("swrd_val", rd, 16'h5A5A);

        sw_in = 16'h1111;
        @(posedge clk); #1;
        do_req(1'b0, 16'hFFF1, 16'h0000);
        chk("swrd_old", rd, 16'h5A5A);
        do_req(1'b0, 16'hFFF1, 16'h0000);
        chk("swrd_new", rd, 16'h1111);

        do_req(1'b1, 16'hFFF2, 16'hFFFE);
        chk("tmrwr_lat", lat, 1);
        do_req(1'b0, 16'hFFF2, 16'h0000);
        chk("tmr_wrap", rd, 16'h0000);
        do_req(1'b0, 16'hFFF2, 16'h0000);
        chk("tmr_sp2", rd, 16'h0002);
        repeat (3) @(posedge clk);
        #1;
        do_req(1'b0, 16'hFFF2, 16'h0000);
        chk("tmr_sp5", rd, 16'h0007);

        do_req(1'b1, 16'hFFF3, 16'hCAFE);
        do_req(1'b0, 16'hFFF3, 16'h0000);
        chk("scr_val", rd, 16'hCAFE);
        do_req(1'b1, 16'hFFF7, 16'h9999);
        chk("unm_wlat", lat, 1);
        do_req(1'b0, 16'hFFF7, 16'h0000);
        chk("unm_val", rd, 16'h0000);

        // Abort a RAM read with reset while it waits for RAM data
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 16'h0000;
        rst = 1'b1;
        @(negedge clk);
        chk("abrt_rvalid", resp_valid, 0);
        chk("abrt_rdata",  resp_rdata, 0);
        chk("abrt_led",    led_out,    0);
        @(posedge clk); #1;
        rst = 1'b0;
        nrv = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) nrv++;
            @(posedge clk); #1;
        end
        chk("abrt_noresp", nrv,       0);
        chk("abrt_ready",  req_ready, 1);
        do_req(1'b0, 16'hFFF2, 16'h0000);
        chk("abrt_tmr", rd, 16'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
